// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg - shared constants for the PET keyboard path.
//
// The keyboard scanner and pia1 both import this package. It holds the matrix
// geometry, the RPi bus addresses of the keyboard image and its status byte,
// the scan-state encoding and the "no keys pressed" byte value.
// -----------------------------------------------------------------------------
package kbd_pkg;

   localparam int          KBD_ROWS        = 10;
   localparam logic [16:0] KBD_BASE_ADDR   = 17'hE800;
   localparam logic [16:0] KBD_STATUS_ADDR = 17'hE80A;
   localparam logic [7:0]  KBD_IDLE_BYTE   = 8'hFF;

   typedef enum logic [1:0] {
      KBD_ST_IDLE   = 2'd0,
      KBD_ST_DRIVE  = 2'd1,
      KBD_ST_SAMPLE = 2'd2,
      KBD_ST_NEXT   = 2'd3
   } kbd_state_e;

   // True when the address falls inside the keyboard image window.
   function automatic logic kbd_is_matrix_addr(input logic [16:0] a, input int rows);
      return (a >= KBD_BASE_ADDR) && (a < (KBD_BASE_ADDR + 17'(rows)));
   endfunction

endpackage

// File: rtl/kbd_scanner_if.sv
// -----------------------------------------------------------------------------
// kbd_scanner_if - RPi read bus between the RPi bridge and the keyboard scanner.
//
// Signals:
//   addr            RPi bus address (17 bits)
//   pi_read_strobe  1-cycle read request
//   data_out        registered read data
//   data_valid      1-cycle pulse one clock after an accepted read
// Modports: master = RPi side, slave = keyboard scanner.
// -----------------------------------------------------------------------------
interface kbd_scanner_if;
   logic [16:0] addr;
   logic        pi_read_strobe;
   logic [7:0]  data_out;
   logic        data_valid;

   modport master (output addr, output pi_read_strobe, input data_out, input data_valid);
   modport slave  (input addr, input pi_read_strobe, output data_out, output data_valid);
endinterface

// File: rtl/kbd_debounce_row.sv
// -----------------------------------------------------------------------------
// kbd_debounce_row - per-key debounce counters for one keyboard matrix row.
//
// Each of the 8 key bits owns a counter. A sample that disagrees with the
// stored bit advances the counter; an agreeing sample clears it. Once the
// counter reaches DEBOUNCE_SCANS the bit flips and the counter clears.
//
// Ports:
//   clk, res    clock, synchronous active-high reset
//   sample_en   this row is being committed this cycle
//   sample      raw column sample (active-low)
//   stored      currently stored row byte
//   next_byte   byte to commit when sample_en is high
// -----------------------------------------------------------------------------
module kbd_debounce_row
   import kbd_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       res,
   input  logic       sample_en,
   input  logic [7:0] sample,
   input  logic [7:0] stored,
   output logic [7:0] next_byte
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   logic [CNT_W-1:0] cnt_r    [8];
   logic [CNT_W-1:0] cnt_nx_s [8];
   logic [7:0]       byte_nx_s;

   // Next counter values and next stored bits for the row.
   always_comb begin
      byte_nx_s = stored;
      for (int b = 0; b < 8; b++) begin
         cnt_nx_s[b] = cnt_r[b];
         if (sample[b] != stored[b]) begin
            // The increment that would reach DEBOUNCE_SCANS flips the bit instead.
            if (cnt_r[b] == CNT_LAST) begin
               byte_nx_s[b] = sample[b];
               cnt_nx_s[b]  = {CNT_W{1'b0}};
            end else begin
               cnt_nx_s[b]  = cnt_r[b] + CNT_W'(1);
            end
         end else begin
            cnt_nx_s[b] = {CNT_W{1'b0}};
         end
      end
   end

   // Counters advance only when this row is committed.
   always_ff @(posedge clk) begin
      if (res) begin
         for (int b = 0; b < 8; b++) begin
            cnt_r[b] <= {CNT_W{1'b0}};
         end
      end else if (sample_en) begin
         for (int b = 0; b < 8; b++) begin
            cnt_r[b] <= cnt_nx_s[b];
         end
      end
   end

   assign next_byte = byte_nx_s;

endmodule

// File: rtl/kbd_scanner.sv
// -----------------------------------------------------------------------------
// kbd_scanner - PET keyboard matrix scanner and RPi-readable snapshot.
//
// Walks the rows, lets each settle for SETTLE_CYCLES clocks, samples the
// active-low columns and stores a 10-byte image (0 = pressed) readable at
// $E800..$E809. $E80A returns {changed, scan_en, 2'b00, row_sel}; reading it
// clears the changed flag (a same-cycle set wins).
//
// Optional feature macro: KBD_SCANNER_DEBOUNCE_EN - per-key debounce counters
// (kbd_debounce_row per row). Undefined: raw samples are stored directly.
//
// Ports:
//   clk, res      clock, synchronous active-high reset
//   scan_en       1 = keep scanning; 0 = park in IDLE after the current row
//   row_sel       row driven to the keyboard decoder
//   row_drive_en  row_sel is valid and driven
//   col_in        column sense lines, active-low, already synchronised
//   bus           RPi read bus (kbd_scanner_if.slave)
//   frame_done    1-cycle pulse after the last row is committed
// -----------------------------------------------------------------------------
module kbd_scanner
   import kbd_pkg::*;
#(
   parameter int ROWS           = KBD_ROWS,
   parameter int SETTLE_CYCLES  = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic         clk,
   input  logic         res,
   input  logic         scan_en,
   output logic [3:0]   row_sel,
   output logic         row_drive_en,
   input  logic [7:0]   col_in,
   kbd_scanner_if.slave bus,
   output logic         frame_done
);

   localparam logic [1:0] S_IDLE   = KBD_ST_IDLE;
   localparam logic [1:0] S_DRIVE  = KBD_ST_DRIVE;
   localparam logic [1:0] S_SAMPLE = KBD_ST_SAMPLE;
   localparam logic [1:0] S_NEXT   = KBD_ST_NEXT;

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       ROW_LAST    = 4'(ROWS - 1);

   logic [1:0]       state_r, state_nx_s;
   logic [SET_W-1:0] settle_r, settle_nx_s;
   logic [3:0]       row_sel_r, row_nx_s;
   logic [7:0]       matrix_r [ROWS];
   logic             changed_r;
   logic [7:0]       commit_byte_s;
   logic             sample_s;
   logic             byte_changed_s;
   logic             rd_matrix_s, rd_status_s;
   logic [7:0]       data_out_r;
   logic             data_valid_r;
   logic             row_drive_en_r;
   logic             frame_done_r;

   assign sample_s       = (state_r == S_SAMPLE);
   assign byte_changed_s = (commit_byte_s != matrix_r[row_sel_r]);
   assign rd_matrix_s    = bus.pi_read_strobe && kbd_is_matrix_addr(bus.addr, ROWS);
   assign rd_status_s    = bus.pi_read_strobe && (bus.addr == KBD_STATUS_ADDR);

`ifdef KBD_SCANNER_DEBOUNCE_EN
   logic [7:0] deb_byte_s [ROWS];

   for (genvar r = 0; r < ROWS; r++) begin : g_deb
      kbd_debounce_row #(
         .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
      ) u_row (
         .clk       (clk),
         .res       (res),
         .sample_en (sample_s && (row_sel_r == 4'(r))),
         .sample    (col_in),
         .stored    (matrix_r[r]),
         .next_byte (deb_byte_s[r])
      );
   end

   assign commit_byte_s = deb_byte_s[row_sel_r];
`else
   // DEBOUNCE_SCANS only shapes the optional debounce counters.
   if (DEBOUNCE_SCANS < 1) begin : g_debounce_unused
   end

   assign commit_byte_s = col_in;
`endif

   // Scan FSM next-state, settle counter and row pointer.
   always_comb begin
      state_nx_s  = state_r;
      settle_nx_s = settle_r;
      row_nx_s    = row_sel_r;
      case (state_r)
         S_IDLE: begin
            row_nx_s    = 4'd0;
            settle_nx_s = {SET_W{1'b0}};
            if (scan_en) begin
               state_nx_s = S_DRIVE;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_DRIVE: begin
            if (settle_r == SETTLE_LAST) begin
               settle_nx_s = {SET_W{1'b0}};
               state_nx_s  = S_SAMPLE;
            end else begin
               settle_nx_s = settle_r + SET_W'(1);
            end
         end
         S_SAMPLE: begin
            state_nx_s = S_NEXT;
         end
         S_NEXT: begin
            if (row_sel_r == ROW_LAST) begin
               row_nx_s   = 4'd0;
               state_nx_s = scan_en ? S_DRIVE : S_IDLE;
            end else if (scan_en) begin
               row_nx_s   = row_sel_r + 4'd1;
               state_nx_s = S_DRIVE;
            end else begin
               row_nx_s   = 4'd0;
               state_nx_s = S_IDLE;
            end
         end
         default: begin
            state_nx_s  = S_IDLE;
            row_nx_s    = 4'd0;
            settle_nx_s = {SET_W{1'b0}};
         end
      endcase
   end

   // FSM registers and registered scan outputs.
   always_ff @(posedge clk) begin
      if (res) begin
         state_r        <= S_IDLE;
         settle_r       <= {SET_W{1'b0}};
         row_sel_r      <= 4'd0;
         row_drive_en_r <= 1'b0;
         frame_done_r   <= 1'b0;
      end else begin
         state_r        <= state_nx_s;
         settle_r       <= settle_nx_s;
         row_sel_r      <= row_nx_s;
         // The row stays driven through its sample cycle.
         row_drive_en_r <= (state_nx_s == S_DRIVE) || (state_nx_s == S_SAMPLE);
         frame_done_r   <= sample_s && (row_sel_r == ROW_LAST);
      end
   end

   // Matrix image and changed flag; a commit beats a status-read clear.
   always_ff @(posedge clk) begin
      if (res) begin
         for (int r = 0; r < ROWS; r++) begin
            matrix_r[r] <= KBD_IDLE_BYTE;
         end
         changed_r <= 1'b0;
      end else begin
         if (sample_s) begin
            matrix_r[row_sel_r] <= commit_byte_s;
         end
         if (sample_s && byte_changed_s) begin
            changed_r <= 1'b1;
         end else if (rd_status_s) begin
            changed_r <= 1'b0;
         end
      end
   end

   // RPi read port; unmatched addresses leave data_out untouched.
   always_ff @(posedge clk) begin
      if (res) begin
         data_out_r   <= KBD_IDLE_BYTE;
         data_valid_r <= 1'b0;
      end else begin
         data_valid_r <= rd_matrix_s || rd_status_s;
         if (rd_matrix_s) begin
            data_out_r <= matrix_r[bus.addr[3:0]];
         end else if (rd_status_s) begin
            data_out_r <= {changed_r, scan_en, 2'b00, row_sel_r};
         end
      end
   end

   assign row_sel        = row_sel_r;
   assign row_drive_en   = row_drive_en_r;
   assign frame_done     = frame_done_r;
   assign bus.data_out   = data_out_r;
   assign bus.data_valid = data_valid_r;

endmodule

// File: tb/tb_kbd_scanner.sv
module tb_kbd_scanner;
   import kbd_pkg::*;

   localparam int ROWS   = 10;
   localparam int SETTLE = 16;
   localparam int DEB    = 4;
   localparam int FRAME  = ROWS * (SETTLE + 2);

   logic       clk = 1'b0;
   logic       res;
   logic       scan_en;
   logic [3:0] row_sel;
   logic       row_drive_en;
   logic [7:0] col_in;
   logic       frame_done;
   logic [7:0] key_img [ROWS];

   kbd_scanner_if bus ();

   // Keyboard model: the selected row presents its key pattern.
   assign col_in = key_img[row_sel];

   kbd_scanner #(
      .ROWS           (ROWS),
      .SETTLE_CYCLES  (SETTLE),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk          (clk),
      .res          (res),
      .scan_en      (scan_en),
      .row_sel      (row_sel),
      .row_drive_en (row_drive_en),
      .col_in       (col_in),
      .bus          (bus),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model of the stored image.
   logic [7:0] m_mat [ROWS];
   logic       m_changed;
   logic [7:0] m_last_data;
`ifdef KBD_SCANNER_DEBOUNCE_EN
   int m_cnt [ROWS][8];
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < ROWS; r++) begin
         m_mat[r] = 8'hFF;
`ifdef KBD_SCANNER_DEBOUNCE_EN
         for (int b = 0; b < 8; b++) m_cnt[r][b] = 0;
`endif
      end
      m_changed   = 1'b0;
      m_last_data = 8'hFF;
   endtask

   task automatic model_row(input int r);
      logic [7:0] s;
      logic [7:0] n;
      s = key_img[r];
`ifdef KBD_SCANNER_DEBOUNCE_EN
      n = m_mat[r];
      for (int b = 0; b < 8; b++) begin
         if (s[b] != m_mat[r][b]) begin
            m_cnt[r][b] = m_cnt[r][b] + 1;
            if (m_cnt[r][b] >= DEB) begin
               n[b] = s[b];
               m_cnt[r][b] = 0;
            end
         end else begin
            m_cnt[r][b] = 0;
         end
      end
`else
      n = s;
`endif
      if (n != m_mat[r]) m_changed = 1'b1;
      m_mat[r] = n;
   endtask

   // One read while idle; expected value comes from the model.
   task automatic bus_read_check(input logic [16:0] a, input string tag);
      logic [7:0] exp_d;
      logic       exp_v;
      exp_v = 1'b1;
      if (a >= KBD_BASE_ADDR && a < KBD_BASE_ADDR + 17'd10) begin
         exp_d = m_mat[int'(a - KBD_BASE_ADDR)];
      end else if (a == KBD_STATUS_ADDR) begin
         exp_d = {m_changed, scan_en, 2'b00, 4'h0};
         m_changed = 1'b0;
      end else begin
         exp_d = m_last_data;
         exp_v = 1'b0;
      end
      bus.addr = a;
      bus.pi_read_strobe = 1'b1;
      @(negedge clk);
      bus.pi_read_strobe = 1'b0;
      check_eq({tag, "_valid"}, bus.data_valid, exp_v);
      check_eq({tag, "_data"}, bus.data_out, exp_d);
      m_last_data = exp_d;
   endtask

   task automatic wait_frame_done();
      for (int n = 0; n < 3 * FRAME && !frame_done; n++) @(negedge clk);
      check_eq("frame_done_seen", frame_done, 1'b1);
   endtask

   // Exactly one frame from IDLE, then park.
   task automatic run_frame();
      scan_en = 1'b1;
      @(negedge clk);
      wait_frame_done();
      for (int r = 0; r < ROWS; r++) model_row(r);
      scan_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_row_driven(input logic [3:0] r);
      for (int n = 0; n < 3 * FRAME && !(row_sel == r && row_drive_en); n++) @(negedge clk);
      check_eq("row_reached", {row_sel, row_drive_en}, {r, 1'b1});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seq_bad;
      int seq_chg;
      int fd_seen;
      logic [3:0] prev_row;

      res = 1'b1;
      scan_en = 1'b0;
      bus.addr = 17'h0;
      bus.pi_read_strobe = 1'b0;
      for (int r = 0; r < ROWS; r++) key_img[r] = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_row_sel", row_sel, 4'd0);
      check_eq("rst_drive_en", row_drive_en, 1'b0);
      check_eq("rst_data_out", bus.data_out, 8'hFF);
      check_eq("rst_data_valid", bus.data_valid, 1'b0);
      check_eq("rst_frame_done", frame_done, 1'b0);
      res = 1'b0;
      @(negedge clk);

      // 1: empty image and clear status after reset.
      for (int r = 0; r < ROWS; r++) bus_read_check(KBD_BASE_ADDR + 17'(r), "t1_row");
      bus_read_check(KBD_STATUS_ADDR, "t1_status");

      // 2: one key on row 3.
      key_img[3] = 8'hFE;
      run_frame();
      for (int r = 0; r < ROWS; r++) bus_read_check(KBD_BASE_ADDR + 17'(r), "t2_row");
      bus_read_check(KBD_STATUS_ADDR, "t2_status1");
      bus_read_check(KBD_STATUS_ADDR, "t2_status2");
      bus_read_check(17'hE80B, "t2_noresp_hi");
      bus_read_check(17'hE7FF, "t2_noresp_lo");

      // Back-to-back strobes, each answered one cycle later.
      bus.addr = 17'hE803;
      bus.pi_read_strobe = 1'b1;
      @(negedge clk);
      check_eq("b2b_first", {bus.data_valid, bus.data_out}, {1'b1, m_mat[3]});
      bus.addr = 17'hE800;
      @(negedge clk);
      bus.pi_read_strobe = 1'b0;
      check_eq("b2b_second", {bus.data_valid, bus.data_out}, {1'b1, m_mat[0]});
      m_last_data = m_mat[0];
      @(negedge clk);
      check_eq("b2b_valid_drop", bus.data_valid, 1'b0);

      // 3: frame period and row sequence under continuous scanning.
      scan_en = 1'b1;
      @(negedge clk);
      wait_frame_done();
      for (int r = 0; r < ROWS; r++) model_row(r);
      check_eq("t3_last_row", row_sel, 4'd9);
      n = 0;
      seq_bad = 0;
      seq_chg = 0;
      prev_row = row_sel;
      do begin
         @(negedge clk);
         n++;
         if (row_sel != prev_row) begin
            seq_chg++;
            if (row_sel != ((prev_row == 4'd9) ? 4'd0 : prev_row + 4'd1)) seq_bad++;
            prev_row = row_sel;
         end
      end while (!frame_done && n < 3 * FRAME);
      check_eq("t3_period", n, FRAME);
      check_eq("t3_row_seq_bad", seq_bad, 0);
      check_eq("t3_row_changes", seq_chg, ROWS);
      for (int r = 0; r < ROWS; r++) model_row(r);
      scan_en = 1'b0;
      @(negedge clk);
      check_eq("t3_wrap_row", row_sel, 4'd0);
      @(negedge clk);
      check_eq("t3_parked", row_drive_en, 1'b0);

      // Randomized frames against the model.
      for (int f = 0; f < 6; f++) begin
         for (int r = 0; r < ROWS; r++) begin
            key_img[r] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
         end
         run_frame();
         bus_read_check(KBD_STATUS_ADDR, "rnd_status");
         bus_read_check(KBD_BASE_ADDR + 17'($urandom_range(0, ROWS - 1)), "rnd_row_a");
         bus_read_check(KBD_BASE_ADDR + 17'($urandom_range(0, ROWS - 1)), "rnd_row_b");
         bus_read_check(17'hE80B + 17'($urandom_range(0, 300)), "rnd_noresp");
      end
      for (int r = 0; r < ROWS; r++) bus_read_check(KBD_BASE_ADDR + 17'(r), "rnd_all");

      // 5: scan_en dropped during DRIVE of row 6.
      for (int r = 0; r < ROWS; r++) key_img[r] = 8'($urandom);
      scan_en = 1'b1;
      @(negedge clk);
      wait_row_driven(4'd6);
      scan_en = 1'b0;
      fd_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
      end
      for (int r = 0; r <= 6; r++) model_row(r);
      check_eq("t5_no_frame_done", fd_seen, 0);
      check_eq("t5_idle_drive_en", row_drive_en, 1'b0);
      check_eq("t5_idle_row_sel", row_sel, 4'd0);
      for (int r = 0; r < ROWS; r++) bus_read_check(KBD_BASE_ADDR + 17'(r), "t5_row");
      bus_read_check(KBD_STATUS_ADDR, "t5_status");

      // 6: reset during SAMPLE of row 2 with keys held.
      for (int r = 0; r < ROWS; r++) key_img[r] = 8'h5A;
      bus_read_check(KBD_BASE_ADDR + 17'd4, "t6_pre");
      scan_en = 1'b1;
      @(negedge clk);
      wait_row_driven(4'd2);
      repeat (SETTLE) @(negedge clk);
      res = 1'b1;
      scan_en = 1'b0;
      @(negedge clk);
      res = 1'b0;
      model_reset();
      check_eq("t6_row_sel", row_sel, 4'd0);
      check_eq("t6_drive_en", row_drive_en, 1'b0);
      check_eq("t6_data_out", bus.data_out, 8'hFF);
      check_eq("t6_data_valid", bus.data_valid, 1'b0);
      check_eq("t6_frame_done", frame_done, 1'b0);
      bus_read_check(17'hE802, "t6_row2");
      bus_read_check(17'hE800, "t6_row0");
      bus_read_check(KBD_STATUS_ADDR, "t6_status");

      // 4: row 5 col 2 pressed 3 frames, released, then pressed 4 frames.
      for (int r = 0; r < ROWS; r++) key_img[r] = 8'hFF;
      key_img[5] = 8'hFB;
      repeat (3) run_frame();
      bus_read_check(17'hE805, "t4_after3");
      key_img[5] = 8'hFF;
      run_frame();
      bus_read_check(17'hE805, "t4_released");
      key_img[5] = 8'hFB;
      repeat (4) run_frame();
      bus_read_check(17'hE805, "t4_after4");
      check_eq("t4_pressed_value", m_last_data, 8'hFB);
      bus_read_check(KBD_STATUS_ADDR, "t4_status");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kbd_scanner.md
Name: kbd_scanner

Overview:
- Scans the physical PET keyboard matrix (10 rows x 8 columns) and holds a debounced snapshot of it.
- Produces the same 10-byte image that the RPi writes into the PIA1 keyboard cache at $E800..$E809. This block is the reader/producer side of that path.
- The RPi reads the snapshot over the bus at $E800..$E809 and a status byte at $E80A.
- Sits beside pia1 on the RPi bus. It does not interact with CPU traffic.

Parameters:
- ROWS, 10, number of matrix rows scanned (row index 0..ROWS-1).
- SETTLE_CYCLES, 16, clk cycles between driving a row and sampling its columns (minimum 1).
- DEBOUNCE_SCANS, 4, consecutive identical samples required before a key bit changes (used only with the optional feature; minimum 1).

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous, active-high reset.
- scan_en  in  1  1 = scanning runs; 0 = FSM parks in IDLE after finishing the current row.
- row_sel  out  4  row currently driven to the keyboard decoder.
- row_drive_en  out  1  1 = row_sel is valid and driven.
- col_in  in  8  column sense lines, active-low (0 = key pressed). Already synchronised externally.
- addr  in  17  RPi bus address.
- pi_read_strobe  in  1  1-cycle pulse for an RPi read.
- data_out  out  8  read data, registered.
- data_valid  out  1  pulses 1 cycle after an accepted read.
- frame_done  out  1  1-cycle pulse when the last row's sample is committed.

Behaviour:
- Reset (synchronous, res=1 at posedge):
  - All 10 matrix bytes = 8'hFF (no keys).
  - row_sel=0, row_drive_en=0, data_out=8'hFF, data_valid=0, frame_done=0.
  - changed flag=0, state=IDLE, settle counter=0, debounce counters=0.
  - A reset mid-scan or mid-read discards the operation with no partial commit.
- FSM states are IDLE, DRIVE, SAMPLE, NEXT.
  - IDLE: row_drive_en=0. Goes to DRIVE when scan_en=1, with row_sel=0.
  - DRIVE: row_drive_en=1. The settle counter counts 0..SETTLE_CYCLES-1, then goes to SAMPLE.
  - SAMPLE: takes one cycle. Captures col_in into the row's stored byte (debounce rules below). Goes to NEXT.
  - NEXT, when row_sel = ROWS-1:
    - row_sel wraps to 0.
    - frame_done pulses in this cycle.
    - Goes to IDLE if scan_en=0, otherwise to DRIVE.
  - NEXT, otherwise: row_sel increments and goes to DRIVE if scan_en=1, or to IDLE (row_sel reset to 0) if scan_en=0.
  - Per-row latency is SETTLE_CYCLES+2 clocks. Full frame = ROWS*(SETTLE_CYCLES+2).
- Storage format: 0 = pressed, identical to the PIA port-B image.
- Changed flag:
  - Set when any committed byte differs from its previous value.
  - Cleared by an RPi read of $E80A.
  - If a set and a clear happen in the same cycle, set wins.
- Bus reads (pi_read_strobe=1):
  - addr $E800..$E809: data_out <= matrix[addr[3:0]] on the next edge, data_valid=1 for one cycle.
  - addr $E80A: data_out <= {changed, scan_en, 2'b00, row_sel}. The changed flag is cleared.
  - Any other addr: no response; data_out holds its value and data_valid=0.
- Read and commit in the same cycle: the read returns the pre-commit value.
- Back-to-back strobes are legal. Each is serviced with 1-cycle latency.

Optional Feature:
- Macro: KBD_SCANNER_DEBOUNCE_EN.
- Defined:
  - Each of the 80 key bits has its own saturating counter, ceil(log2(DEBOUNCE_SCANS+1)) bits wide.
  - When a sample differs from the stored bit, the counter increments. When it matches, the counter resets to 0.
  - When the counter reaches DEBOUNCE_SCANS, the stored bit flips and the counter clears.
- Undefined: the raw col_in is stored directly at SAMPLE, and no counters are instantiated.

Decomposition:
- Shared package kbd_pkg holds:
  - KBD_ROWS=10.
  - KBD_BASE_ADDR=17'hE800.
  - KBD_STATUS_ADDR=17'hE80A.
  - Scan-state enum {IDLE, DRIVE, SAMPLE, NEXT}.
  - KBD_IDLE_BYTE=8'hFF.
- pia1 imports the same base address constants.
- One natural sub-module: kbd_debounce_row. It holds the 8 per-bit counters for one row and is instantiated ROWS times under the macro.

Test Plan:
1. Reset, then read $E800..$E809 -> every read returns 8'hFF with data_valid 1 cycle after the strobe. Read $E80A -> 8'h00.
2. scan_en=1, col_in=8'hFE only while row_sel=3, macro off -> after one frame_done, $E803 reads 8'hFE, all other rows read 8'hFF, and $E80A bit7=1. A second read of $E80A shows bit7=0.
3. Frame timing with SETTLE_CYCLES=16 -> frame_done pulses every 180 clocks. row_sel sequence is 0..9 then wraps to 0.
4. Macro on, DEBOUNCE_SCANS=4, row 5 col 2 pressed for 3 frames then released -> $E805 stays 8'hFF. Pressed for 4 frames -> $E805 = 8'hFB.
5. scan_en dropped while in DRIVE of row 6 -> row 6 completes, then IDLE with row_drive_en=0 and row_sel=0. No frame_done pulse occurs.
6. res asserted during SAMPLE of row 2 with a key held -> the next cycle has all outputs at reset values and $E802 reads 8'hFF.
